// File: rtl/ddr2_req_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// ddr2_req_arbiter : round-robin scheduler of DDR2 burst requests onto
//                    the write/read master command ports
// Rev 1.0
// ------------------------------------------------------------------
module ddr2_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDW        = 2,
  parameter int ADDR_WIDTH = 26,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_end,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic                          wr_trig,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [7:0]                    wr_len,
  input  logic                          wr_ready,
  input  logic                          wr_done,
  output logic                          rd_trig,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [7:0]                    rd_len,
  input  logic                          rd_ready,
  input  logic                          rd_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT - 1);

  state_t                  state, state_nxt;
  logic [IDW-1:0]          ptr, ptr_nxt;
  logic [IDW-1:0]          id, id_nxt;
  logic                    we, we_nxt;
  logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
  logic [7:0]              len, len_nxt;
  logic [15:0]             cnt, cnt_nxt;
  logic                    zpend, zpend_nxt;
  logic                    wtrig, wtrig_nxt;
  logic                    rtrig, rtrig_nxt;
  logic [NUM_REQ-1:0]      ready_q, ready_nxt;
  logic [NUM_REQ-1:0]      done_q, done_nxt;
  logic [NUM_REQ-1:0]      err_q, err_nxt;

  logic                    found;
  logic [IDW-1:0]          win;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [7:0]              sel_len;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Scan downwards so the last hit is the first requester at or after ptr.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    win      = '0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        found    = 1'b1;
        win      = IDW'(idx);
        sel_we   = req_we[idx];
        sel_addr = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[idx*8 +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    id_nxt    = id;
    we_nxt    = we;
    addr_nxt  = addr;
    len_nxt   = len;
    cnt_nxt   = cnt;
    zpend_nxt = 1'b0;
    wtrig_nxt = wtrig;
    rtrig_nxt = rtrig;
    ready_nxt = '0;
    done_nxt  = '0;
    err_nxt   = '0;
    case (state)
      S_IDLE: begin
        wtrig_nxt = 1'b0;
        rtrig_nxt = 1'b0;
        cnt_nxt   = '0;
        // A zero-length grant completes here; its cycle doubles as the idle gap.
        if (zpend) begin
          done_nxt[id] = 1'b1;
        end else if (init_end && found) begin
          id_nxt         = win;
          we_nxt         = sel_we;
          addr_nxt       = sel_addr;
          len_nxt        = sel_len;
          ready_nxt[win] = 1'b1;
          if (sel_len == 8'd0) begin
            zpend_nxt = 1'b1;
            ptr_nxt   = next_ptr(win);
          end else begin
            state_nxt = S_ISSUE;
            wtrig_nxt = sel_we;
            rtrig_nxt = ~sel_we;
          end
        end
      end
      S_ISSUE: begin
        if (!init_end) begin
          state_nxt = S_IDLE;
          wtrig_nxt = 1'b0;
          rtrig_nxt = 1'b0;
        end else if ((wtrig && wr_ready) || (rtrig && rd_ready)) begin
          state_nxt = S_WAIT;
          wtrig_nxt = 1'b0;
          rtrig_nxt = 1'b0;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (!init_end) begin
          state_nxt = S_IDLE;
        end else if ((we && wr_done) || (!we && rd_done)) begin
          done_nxt[id] = 1'b1;
          ptr_nxt      = next_ptr(id);
          state_nxt    = S_IDLE;
        end else if (cnt == C_CNT_LAST) begin
          done_nxt[id] = 1'b1;
          err_nxt[id]  = 1'b1;
          ptr_nxt      = next_ptr(id);
          state_nxt    = S_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        wtrig_nxt = 1'b0;
        rtrig_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      id      <= '0;
      we      <= 1'b0;
      addr    <= '0;
      len     <= '0;
      cnt     <= '0;
      zpend   <= 1'b0;
      wtrig   <= 1'b0;
      rtrig   <= 1'b0;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      id      <= id_nxt;
      we      <= we_nxt;
      addr    <= addr_nxt;
      len     <= len_nxt;
      cnt     <= cnt_nxt;
      zpend   <= zpend_nxt;
      wtrig   <= wtrig_nxt;
      rtrig   <= rtrig_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  assign req_ready = ready_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign grant_id  = id;
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign wr_trig   = wtrig;
  assign rd_trig   = rtrig;
  assign wr_addr   = addr;
  assign wr_len    = len;
  assign rd_addr   = addr;
  assign rd_len    = len;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_req_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ddr2_req_arbiter : directed scoreboard bench for ddr2_req_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr2_req_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 26;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst, init_end;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [N-1:0]    req_ready, req_done, req_err;
  logic [IW-1:0]   grant_id;
  logic            busy, wr_trig, rd_trig;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [7:0]      wr_len, rd_len;
  logic            wr_ready, wr_done, rd_ready, rd_done;

  ddr2_req_arbiter #(.NUM_REQ(N), .IDW(IW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .grant_id(grant_id), .busy(busy),
    .wr_trig(wr_trig), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    logic [N-1:0]  vec;
    logic [N-1:0]  err;
    logic [IW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ready(input int id);
    exp_t e;
    e.is_done = 1'b0; e.vec = N'(1 << id); e.err = '0; e.id = IW'(id);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int id, input bit err);
    exp_t e;
    e.is_done = 1'b1; e.vec = N'(1 << id); e.err = err ? N'(1 << id) : '0; e.id = IW'(id);
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [7:0] l);
    req_we[i]          = we;
    req_addr[i*AW +: AW] = a;
    req_len[i*8 +: 8]  = l;
    req_valid[i]       = 1'b1;
  endtask

  // Returns at the negedge where req_ready is seen; the requester withdraws there.
  task automatic wait_ready(output int id);
    id = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
        req_valid = req_valid & ~req_ready;
        return;
      end
    end
    check("ready_timeout", 1, 0);
  endtask

  // Called at the accept negedge with ready already high: handshake, done pulse, latency check.
  task automatic complete(input bit we, input int id, input string name);
    @(negedge clk);
    if (we) wr_done = 1'b1; else rd_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0;
    check(name, longint'(req_done), longint'(1 << id));
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_trig || rd_trig) check("one_trig", longint'(wr_trig & rd_trig), 0);
        if (req_ready != '0) begin
          if (exp_q.size() == 0) check("unexpected_ready", longint'(req_ready), 0);
          else begin
            e = exp_q.pop_front();
            check("sb_kind_ready", longint'(e.is_done), 0);
            check("sb_ready", longint'({grant_id, req_ready}), longint'({e.id, e.vec}));
          end
        end
        if (req_done != '0 || req_err != '0) begin
          if (exp_q.size() == 0) check("unexpected_done", longint'({req_err, req_done}), 0);
          else begin
            e = exp_q.pop_front();
            check("sb_kind_done", longint'(e.is_done), 1);
            check("sb_done", longint'({req_err, req_done}), longint'({e.err, e.vec}));
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int id, n;
    bit bad;
    rst = 1'b1; init_end = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
    wr_ready = 1'b0; wr_done = 1'b0; rd_ready = 1'b0; rd_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", longint'({req_ready, req_done, req_err, grant_id, busy, wr_trig, rd_trig}), 0);
    check("reset_cmd", longint'({wr_addr, wr_len, rd_addr, rd_len}), 0);
    rst = 1'b0;

    // 1: no service before init_end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i * 'h100), 8'd4);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready != '0 || req_done != '0 || wr_trig || rd_trig || busy) bad = 1'b1;
    end
    check("idle_no_init", longint'(bad), 0);

    // 2: round robin 0,1,2,3,0
    init_end = 1'b1; rd_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin push_ready(g % N); push_done(g % N, 1'b0); end
    for (int g = 0; g < 5; g++) begin
      wait_ready(id);
      check("rr_order", id, g % N);
      check("rr_trig", longint'({wr_trig, rd_trig}), 1);
      check("rr_addr", longint'(rd_addr), (g % N) * 'h100);
      complete(1'b0, g % N, "rr_done_lat");
      if (g < 4) set_req(g % N, 1'b0, AW'((g % N) * 'h100), 8'd4);
      else req_valid = '0;
    end
    rd_ready = 1'b0;

    // 3: write with wr_ready held off for 5 cycles
    push_ready(0); push_done(0, 1'b0);
    set_req(0, 1'b1, 26'h40, 8'd32);
    wait_ready(id);
    n = 0; bad = 1'b0;
    for (int c = 0; c < 20 && wr_trig; c++) begin
      n++;
      if (wr_addr != 26'h40 || wr_len != 8'd32 || rd_trig) bad = 1'b1;
      if (n == 6) wr_ready = 1'b1;
      @(negedge clk);
    end
    wr_ready = 1'b0;
    check("wr_trig_cycles", n, 6);
    check("wr_cmd_stable", longint'(bad), 0);
    check("busy_wait", longint'(busy), 1);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    check("wr_done_lat", longint'(req_done), 1);

    // 4: wrong done ignored on a read
    rd_ready = 1'b1;
    push_ready(1); push_done(1, 1'b0);
    set_req(1, 1'b0, 26'h1234, 8'd16);
    wait_ready(id);
    check("rd_grant", id, 1);
    @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      if (req_done != '0 || !busy) bad = 1'b1;
      @(negedge clk);
    end
    check("wrong_done_ignored", longint'(bad), 0);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check("rd_done_lat", longint'(req_done), 2);

    // 5: timeout on requester 2, requester 3 granted afterwards
    push_ready(2); push_done(2, 1'b1); push_ready(3); push_done(3, 1'b0);
    set_req(2, 1'b0, 26'h200, 8'd8);
    set_req(3, 1'b1, 26'h80, 8'd8);
    wait_ready(id);
    check("to_grant", id, 2);
    bad = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i < 17 && (req_done != '0 || req_err != '0)) bad = 1'b1;
    end
    check("to_early", longint'(bad), 0);
    check("to_pulse", longint'({req_err, req_done}), longint'(8'h44));
    wr_ready = 1'b1; rd_ready = 1'b0;
    wait_ready(id);
    check("after_to_grant", id, 3);
    complete(1'b1, 3, "after_to_done");
    wr_ready = 1'b0;

    // 6a: init_end drops in WAIT
    rd_ready = 1'b1;
    push_ready(0);
    set_req(0, 1'b0, 26'h300, 8'd8);
    wait_ready(id);
    @(negedge clk);
    init_end = 1'b0;
    @(negedge clk);
    check("abort_idle", longint'({busy, wr_trig, rd_trig}), 0);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (req_done != '0 || req_err != '0 || req_ready != '0) bad = 1'b1;
    end
    check("abort_no_pulse", longint'(bad), 0);
    init_end = 1'b1;

    // 6b: zero-length requests; ptr still 0 after the abort
    push_ready(0); push_done(0, 1'b0); push_ready(1); push_done(1, 1'b0);
    set_req(0, 1'b1, 26'h10, 8'd0);
    set_req(1, 1'b0, 26'h20, 8'd0);
    bad = 1'b0;
    wait_ready(id);
    check("len0_first", id, 0);
    if (wr_trig || rd_trig) bad = 1'b1;
    @(negedge clk);
    check("len0_done0", longint'(req_done), 1);
    if (wr_trig || rd_trig) bad = 1'b1;
    wait_ready(id);
    check("len0_second", id, 1);
    if (wr_trig || rd_trig) bad = 1'b1;
    @(negedge clk);
    check("len0_done1", longint'(req_done), 2);
    if (wr_trig || rd_trig || busy) bad = 1'b1;
    check("len0_no_trig", longint'(bad), 0);

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
